// File: rtl/iq_integrator.sv
// Purpose: per-shot I/Q demodulating integrator: delay, multiply by LO, accumulate, emit one point.
// Latency: final accepted sample in cycle n -> iq_valid in cycle n+3 (product reg, accumulate, output reg).
// Backpressure: none; the ADC stream is paced by adc_valid, triggers arriving while busy are dropped and flagged.
//
// Ports:
//   clk100, rst_n            clock, synchronous active-low reset
//   trigger                  shot start pulse; cfg_delay/cfg_length latched when it is accepted
//   adc_valid, adc_sample    ADC stream (signed)
//   lo_cos, lo_sin           LO references (signed, 2^(LO_W-2) == +1.0)
//   i_val, q_val, sat        integrated result and saturation flag, held between strobes
//   iq_valid                 one-cycle result strobe
//   busy                     high whenever the FSM is not idle
//   trig_missed              one-cycle pulse the cycle after a dropped trigger
module iq_integrator #(
    parameter int SAMPLE_W   = 16,
    parameter int LO_W       = 16,
    parameter int ACC_W      = 32,
    parameter int PROD_SHIFT = 14
) (
    input  logic                clk100,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic [15:0]         cfg_delay,
    input  logic [15:0]         cfg_length,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_sample,
    input  logic [LO_W-1:0]     lo_cos,
    input  logic [LO_W-1:0]     lo_sin,
    output logic [ACC_W-1:0]    i_val,
    output logic [ACC_W-1:0]    q_val,
    output logic                iq_valid,
    output logic                sat,
    output logic                busy,
    output logic                trig_missed
);

    localparam int PW = SAMPLE_W + LO_W;   // full-precision product width
    localparam int EW = ACC_W + 1;         // shifted product width fed to the accumulator

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_INTEG,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [15:0] dly_r, len_r, cnt;
    logic        accept, take, skip, dly_done, int_done;

    logic signed [PW-1:0] prod_i, prod_q, shp_i, shp_q;
    logic signed [EW-1:0] p_i, p_q;
    logic                 p_vld;

    logic [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
    logic             sat_i, sat_q, ov_i, ov_q;

    // Saturating add: returns {overflow, clamped result}. The sum is formed two bits wider
    // than the accumulator so overflow shows up as disagreement among its top three bits.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [EW-1:0] p);
        logic [ACC_W+1:0] s;
        s = {{2{a[ACC_W-1]}}, a} + {p[EW-1], p};
        if (s[ACC_W+1:ACC_W-1] == 3'b000 || s[ACC_W+1:ACC_W-1] == 3'b111)
            sat_add = {1'b0, s[ACC_W-1:0]};
        else if (!s[ACC_W+1])
            sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
    endfunction

    assign dly_done = (cnt == dly_r - 16'd1);
    assign int_done = (cnt == len_r - 16'd1);

    // State register
    always_ff @(posedge clk100) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cfg_delay != 16'd0)
                        state_nxt = S_DELAY;
                    else if (cfg_length != 16'd0)
                        state_nxt = S_INTEG;
                    else
                        state_nxt = S_DRAIN;
                end
            end
            S_DELAY:  if (skip && dly_done) state_nxt = (len_r != 16'd0) ? S_INTEG : S_DRAIN;
            S_INTEG:  if (take && int_done) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_OUTPUT;
            S_OUTPUT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs. A trigger coinciding with the result strobe (first idle cycle) is
    // still treated as arriving while busy.
    always_comb begin
        busy   = (state != S_IDLE);
        accept = (state == S_IDLE) && trigger && !iq_valid;
        take   = (state == S_INTEG) && adc_valid;
        skip   = (state == S_DELAY) && adc_valid;
    end

    // Stage 1 multiply (full precision, floor shift)
    assign prod_i = PW'($signed(adc_sample)) * PW'($signed(lo_cos));
    assign prod_q = PW'($signed(adc_sample)) * PW'($signed(lo_sin));
    assign shp_i  = prod_i >>> PROD_SHIFT;
    assign shp_q  = prod_q >>> PROD_SHIFT;

    always_comb begin
        {ov_i, sum_i} = sat_add(acc_i, p_i);
        {ov_q, sum_q} = sat_add(acc_q, p_q);
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            dly_r       <= '0;
            len_r       <= '0;
            cnt         <= '0;
            p_i         <= '0;
            p_q         <= '0;
            p_vld       <= 1'b0;
            acc_i       <= '0;
            acc_q       <= '0;
            sat_i       <= 1'b0;
            sat_q       <= 1'b0;
            i_val       <= '0;
            q_val       <= '0;
            sat         <= 1'b0;
            iq_valid    <= 1'b0;
            trig_missed <= 1'b0;
        end else begin
            // One counter serves both phases; it restarts when the delay phase ends.
            if (accept) begin
                dly_r <= cfg_delay;
                len_r <= cfg_length;
                cnt   <= '0;
            end else if (skip) begin
                cnt <= dly_done ? 16'd0 : cnt + 16'd1;
            end else if (take) begin
                cnt <= cnt + 16'd1;
            end

            p_vld <= take;
            if (take) begin
                p_i <= EW'(shp_i);
                p_q <= EW'(shp_q);
            end

            if (accept) begin
                acc_i <= '0;
                acc_q <= '0;
                sat_i <= 1'b0;
                sat_q <= 1'b0;
            end else if (p_vld) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                sat_i <= sat_i | ov_i;
                sat_q <= sat_q | ov_q;
            end

            iq_valid    <= (state == S_OUTPUT);
            trig_missed <= trigger && !accept;
            if (state == S_OUTPUT) begin
                i_val <= acc_i;
                q_val <= acc_q;
                sat   <= sat_i | sat_q;
            end
        end
    end

endmodule

// File: tb/tb_iq_integrator.sv
`timescale 1ns/1ps
module tb_iq_integrator;

    logic        clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic        rst_n, trigger, adc_valid;
    logic [15:0] cfg_delay, cfg_length, adc_sample, lo_cos, lo_sin;
    logic [31:0] i_val14, q_val14, i_val0, q_val0;
    logic        iq_valid14, sat14, busy14, miss14;
    logic        iq_valid0, sat0, busy0, miss0;

    iq_integrator #(.SAMPLE_W(16), .LO_W(16), .ACC_W(32), .PROD_SHIFT(14)) dut14 (
        .clk100(clk100), .rst_n(rst_n), .trigger(trigger),
        .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .adc_valid(adc_valid), .adc_sample(adc_sample), .lo_cos(lo_cos), .lo_sin(lo_sin),
        .i_val(i_val14), .q_val(q_val14), .iq_valid(iq_valid14), .sat(sat14),
        .busy(busy14), .trig_missed(miss14)
    );

    iq_integrator #(.SAMPLE_W(16), .LO_W(16), .ACC_W(32), .PROD_SHIFT(0)) dut0 (
        .clk100(clk100), .rst_n(rst_n), .trigger(trigger),
        .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .adc_valid(adc_valid), .adc_sample(adc_sample), .lo_cos(lo_cos), .lo_sin(lo_sin),
        .i_val(i_val0), .q_val(q_val0), .iq_valid(iq_valid0), .sat(sat0),
        .busy(busy0), .trig_missed(miss0)
    );

    typedef struct {
        longint i;
        longint q;
        bit     s;
        int     c;
    } exp_t;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    exp_t   q14[$];
    exp_t   q0[$];
    exp_t   e14, e0;
    bit     miss_exp[int];
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     t_trig = 0;

    // reference model state, index 0 -> shift 14, index 1 -> shift 0
    longint ai[2], aq[2];
    bit     ms[2];
    int     sh[2] = '{14, 0};

    longint last_i14 = 0, last_q14 = 0, last_i0 = 0, last_q0 = 0;
    bit     last_s14 = 0, last_s0 = 0;
    int     last_c14 = 0;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result strobe appears.
    always @(negedge clk100) begin
        if (iq_valid14) begin
            if (q14.size() == 0) begin
                total++; bad++;
                $display("FAIL d14_unexpected_result: iq_valid=1 at cycle %0d, expected no result", cyc);
            end else begin
                e14 = q14.pop_front();
                chk("d14_i_val", longint'($signed(i_val14)), e14.i);
                chk("d14_q_val", longint'($signed(q_val14)), e14.q);
                chk("d14_sat", longint'(sat14), longint'(e14.s));
                chk("d14_latency_cycle", cyc, e14.c);
            end
            last_i14 = longint'($signed(i_val14));
            last_q14 = longint'($signed(q_val14));
            last_s14 = sat14;
            last_c14 = cyc;
        end
        if (iq_valid0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL d0_unexpected_result: iq_valid=1 at cycle %0d, expected no result", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("d0_i_val", longint'($signed(i_val0)), e0.i);
                chk("d0_q_val", longint'($signed(q_val0)), e0.q);
                chk("d0_sat", longint'(sat0), longint'(e0.s));
                chk("d0_latency_cycle", cyc, e0.c);
            end
            last_i0 = longint'($signed(i_val0));
            last_q0 = longint'($signed(q_val0));
            last_s0 = sat0;
        end
        chk("d14_trig_missed", longint'(miss14), longint'(miss_exp.exists(cyc)));
        chk("d0_trig_missed", longint'(miss0), longint'(miss_exp.exists(cyc)));
    end

    task automatic model_sample(input int smp, input int c, input int sn);
        longint pi, pq;
        for (int k = 0; k < 2; k++) begin
            pi = (longint'(smp) * longint'(c)) >>> sh[k];
            pq = (longint'(smp) * longint'(sn)) >>> sh[k];
            ai[k] = ai[k] + pi;
            aq[k] = aq[k] + pq;
            if (ai[k] > MAXV) begin ai[k] = MAXV; ms[k] = 1'b1; end
            if (ai[k] < MINV) begin ai[k] = MINV; ms[k] = 1'b1; end
            if (aq[k] > MAXV) begin aq[k] = MAXV; ms[k] = 1'b1; end
            if (aq[k] < MINV) begin aq[k] = MINV; ms[k] = 1'b1; end
        end
    endtask

    task automatic push_exp(input int c);
        q14.push_back('{ai[0], aq[0], ms[0], c});
        q0.push_back('{ai[1], aq[1], ms[1], c});
    endtask

    task automatic set_data(input bit rnd, input int fs, input int fc, input int fsn);
        if (rnd) begin
            adc_sample = 16'($urandom);
            lo_cos     = 16'($urandom);
            lo_sin     = 16'($urandom);
        end else begin
            adc_sample = 16'(fs);
            lo_cos     = 16'(fc);
            lo_sin     = 16'(fsn);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk100); #1;
            trigger   = 1'b0;
            adc_valid = 1'($urandom_range(0, 1));
            set_data(1'b1, 0, 0, 0);
        end
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random. xtrig: integrate-sample index at which
    // a stray trigger is fired (-1 none). abort_at: integrate-sample index at which reset
    // is pulsed (-1 none). post_trig: cycle offset after the final sample for a stray trigger.
    task automatic do_shot(input int dly, input int len, input int vmode, input bit rnd,
                           input int fs, input int fc, input int fsn,
                           input int xtrig, input int abort_at, input int post_trig);
        int skipped, taken, k, n;
        bit done, fired;
        skipped = 0; taken = 0; k = 0; fired = 0;
        for (int j = 0; j < 2; j++) begin ai[j] = 0; aq[j] = 0; ms[j] = 0; end
        @(posedge clk100); #1;
        trigger    = 1'b1;
        cfg_delay  = 16'(dly);
        cfg_length = 16'(len);
        adc_valid  = 1'($urandom_range(0, 1));
        set_data(rnd, fs, fc, fsn);
        t_trig = cyc;
        done = (dly == 0 && len == 0);
        if (done) push_exp(cyc + 3);
        while (!done) begin
            @(posedge clk100); #1;
            trigger    = 1'b0;
            cfg_delay  = 16'($urandom);
            cfg_length = 16'($urandom);
            k++;
            case (vmode)
                0:       adc_valid = 1'b1;
                1:       adc_valid = k[0];
                default: adc_valid = ($urandom_range(0, 3) != 0);
            endcase
            set_data(rnd, fs, fc, fsn);
            if (abort_at >= 0 && skipped == dly && taken == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk100); #1;
                rst_n = 1'b1;
                adc_valid = 1'b0;
                chk("abort_busy14", longint'(busy14), 0);
                chk("abort_busy0", longint'(busy0), 0);
                chk("abort_i_val14", longint'($signed(i_val14)), 0);
                chk("abort_q_val0", longint'($signed(q_val0)), 0);
                chk("abort_sat0", longint'(sat0), 0);
                return;
            end
            if (xtrig >= 0 && !fired && skipped == dly && taken == xtrig) begin
                trigger = 1'b1;
                fired = 1'b1;
                miss_exp[cyc + 1] = 1'b1;
            end
            if (adc_valid) begin
                if (skipped < dly) begin
                    skipped++;
                    if (skipped == dly && len == 0) begin push_exp(cyc + 3); done = 1'b1; end
                end else begin
                    model_sample(int'($signed(adc_sample)), int'($signed(lo_cos)), int'($signed(lo_sin)));
                    taken++;
                    if (taken == len) begin push_exp(cyc + 3); done = 1'b1; end
                end
            end
        end
        n = cyc;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk100); #1;
            trigger = (post_trig == j);
            if (trigger) miss_exp[cyc + 1] = 1'b1;
            cfg_delay  = 16'($urandom_range(0, 3));
            cfg_length = 16'($urandom_range(0, 3));
            adc_valid  = 1'($urandom_range(0, 1));
            set_data(1'b1, 0, 0, 0);
        end
        if (cyc != n + 3) $display("note: tail misaligned");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int dly, len, xt, pt;
        rst_n = 1'b0; trigger = 1'b0; adc_valid = 1'b0;
        cfg_delay = '0; cfg_length = '0;
        adc_sample = '0; lo_cos = '0; lo_sin = '0;
        repeat (3) @(posedge clk100);
        #1;
        chk("reset_i_val", longint'($signed(i_val14)), 0);
        chk("reset_q_val", longint'($signed(q_val14)), 0);
        chk("reset_iq_valid", longint'(iq_valid14), 0);
        chk("reset_sat", longint'(sat14), 0);
        chk("reset_busy", longint'(busy14), 0);
        chk("reset_trig_missed", longint'(miss14), 0);
        rst_n = 1'b1;
        idle(2);

        // basic shot: 1000 * 1.0 over 4 samples
        do_shot(2, 4, 0, 1'b0, 1000, 16384, 0, -1, -1, 0);
        idle(1);
        chk("basic_i_val", last_i14, 4000);
        chk("basic_q_val", last_q14, 0);
        chk("basic_sat", longint'(last_s14), 0);
        chk("basic_latency", last_c14 - t_trig, 9);

        // same shot with adc_valid toggling
        do_shot(2, 4, 1, 1'b0, 1000, 16384, 0, -1, -1, 0);
        idle(1);
        chk("toggle_i_val", last_i14, 4000);
        chk("toggle_latency", last_c14 - t_trig, 14);

        // saturation on each channel (shift 0 instance)
        do_shot(0, 3, 0, 1'b0, 32767, 32767, 0, -1, -1, 0);
        idle(1);
        chk("sat_pos_i_val", last_i0, MAXV);
        chk("sat_pos_flag", longint'(last_s0), 1);
        do_shot(0, 3, 0, 1'b0, -32768, 0, 32767, -1, -1, 0);
        idle(1);
        chk("sat_neg_q_val", last_q0, MINV);
        chk("sat_neg_flag", longint'(last_s0), 1);

        // stray trigger during integrate, then triggers in OUTPUT and strobe cycles
        do_shot(2, 4, 0, 1'b0, 1000, 16384, 0, 1, -1, 2);
        do_shot(2, 4, 0, 1'b0, 1000, 16384, 0, -1, -1, 3);
        idle(1);
        chk("xtrig_i_val", last_i14, 4000);

        // zero length, zero delay
        do_shot(0, 0, 0, 1'b0, 1000, 16384, 0, -1, -1, 0);
        idle(1);
        chk("len0_i_val", last_i14, 0);
        chk("len0_latency", last_c14 - t_trig, 3);

        // abort mid-integrate, then a clean shot
        do_shot(1, 10, 0, 1'b1, 0, 0, 0, -1, 4, 0);
        idle(6);
        do_shot(2, 4, 0, 1'b0, 1000, 16384, 0, -1, -1, 0);
        idle(1);
        chk("post_abort_i_val", last_i14, 4000);

        // randomized shots
        for (int r = 0; r < 30; r++) begin
            dly = $urandom_range(0, 4);
            len = $urandom_range(0, 10);
            xt  = (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            pt  = $urandom_range(0, 3);
            do_shot(dly, len, 2, 1'b1, 0, 0, 0, xt, -1, pt);
        end
        do_shot(3, 200, 2, 1'b1, 0, 0, 0, -1, -1, 0);

        idle(6);
        chk("d14_results_pending", q14.size(), 0);
        chk("d0_results_pending", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_integrator.md
Name: iq_integrator

Overview:
- Upstream neighbour of the analysis FSM and the state classifier: it produces the per-shot (i_val, q_val) pair those stages consume.
- On each measurement trigger it waits a programmable delay, then multiplies ADC samples by supplied LO cos/sin references.
- It accumulates the products over a programmable window and emits one signed 32-bit I/Q point with a one-cycle valid strobe.

Parameters:
- SAMPLE_W, 16, ADC sample width (signed two's complement).
- LO_W, 16, LO reference width (signed; 2^(LO_W-2) represents +1.0).
- ACC_W, 32, accumulator and output width (signed).
- PROD_SHIFT, 14, arithmetic right shift applied to each product before accumulation.

Ports:
- clk100  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- trigger  in  1  single-cycle shot start pulse.
- cfg_delay  in  16  number of valid samples to skip after trigger; latched on the accepted trigger.
- cfg_length  in  16  number of valid samples to integrate; latched on the accepted trigger.
- adc_valid  in  1  adc_sample, lo_cos and lo_sin are valid this cycle.
- adc_sample  in  SAMPLE_W  signed ADC sample.
- lo_cos  in  LO_W  signed in-phase LO reference.
- lo_sin  in  LO_W  signed quadrature LO reference.
- i_val  out  ACC_W  signed integrated I result.
- q_val  out  ACC_W  signed integrated Q result.
- iq_valid  out  1  one-cycle strobe: i_val/q_val hold a new result.
- sat  out  1  the result in i_val/q_val saturated on either channel; updated with iq_valid.
- busy  out  1  high in every state except IDLE.
- trig_missed  out  1  one-cycle pulse when a trigger arrives while busy.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; all counters, accumulators and pipeline registers clear.
  - i_val=0, q_val=0, iq_valid=0, sat=0, busy=0, trig_missed=0.
  - Reset mid-shot abandons the shot; no iq_valid is produced for it.
- State machine: IDLE, DELAY, INTEGRATE, DRAIN, OUTPUT.
- IDLE:
  - On trigger=1, latch cfg_delay/cfg_length and clear the accumulators.
  - Go to DELAY if cfg_delay>0; otherwise to INTEGRATE if cfg_length>0; otherwise to DRAIN.
- DELAY:
  - Count cycles with adc_valid=1.
  - After cfg_delay valid samples, go to INTEGRATE (or DRAIN if length=0).
  - Samples in DELAY are discarded.
- INTEGRATE:
  - Each adc_valid=1 cycle accepts one sample.
  - Stage 1 registers p_i = (adc_sample*lo_cos)>>>PROD_SHIFT and p_q = (adc_sample*lo_sin)>>>PROD_SHIFT. Products are full precision (SAMPLE_W+LO_W bits); the shift is arithmetic (floor), then the result is sign-extended to ACC_W+1.
  - Stage 2 adds to the accumulators with saturation at +2^(ACC_W-1)-1 / -2^(ACC_W-1). Once a channel saturates, its sticky saturation flag is set for the shot and the value stays clamped unless later products bring it back in range (saturating add per step).
  - After the cfg_length-th accepted sample, go to DRAIN.
  - adc_valid=0 cycles pause counting; there is no timeout.
- DRAIN: wait one cycle so the final product reaches the accumulator, then go to OUTPUT.
- OUTPUT:
  - Register the accumulators to i_val/q_val and the sticky flags (OR of both channels) to sat.
  - iq_valid=1 for exactly one cycle; return to IDLE.
- Latency: final sample presented in cycle n -> iq_valid high in cycle n+3.
- Length 0: the result is 0/0 with sat=0, iq_valid 3 cycles after the trigger (delay 0) or after the final delay sample.
- i_val/q_val/sat hold their values between strobes.
- Trigger while busy (including the OUTPUT cycle):
  - The trigger is ignored and the shot in progress is unaffected.
  - trig_missed pulses in the following cycle.
- Trigger in the same cycle the FSM returns to IDLE: treated as busy (ignored).
- Counters are 16 bits; max delay/length = 65535 valid samples; no wrap inside a shot.

Test Plan:
- PROD_SHIFT=14, delay=2, length=4, adc_sample=1000, lo_cos=16384, lo_sin=0, adc_valid held 1 -> one iq_valid, i_val=4000, q_val=0, sat=0, 9 cycles after trigger.
- Same shot with adc_valid toggling 1/0 every cycle -> identical result; iq_valid 3 cycles after the 6th valid sample.
- PROD_SHIFT=0, length=3, adc_sample=32767, lo_cos=32767 -> i_val=2147483647, sat=1. With adc_sample=-32768, lo_sin=32767 -> q_val=-2147483648, sat=1.
- Second trigger asserted during INTEGRATE -> trig_missed pulses once and the first result is unchanged. A trigger 1 cycle after iq_valid is accepted normally.
- length=0, delay=0 -> i_val=0, q_val=0, iq_valid 3 cycles after trigger.
- rst_n=0 for 1 cycle mid-INTEGRATE -> busy=0, outputs 0 and no iq_valid. A new trigger then yields a correct fresh result with no residue from the aborted shot.
